// File: rtl/ring_counter_monitor_pkg.sv
// Shared types and helpers for the one-hot ring counter monitor.
// Helpers work on a fixed maximum width so callers of any WIDTH up to RING_MAX_W can share them.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;
    localparam int         RING_MAX_W  = 64;
    localparam int         RING_IDX_W  = 6;

    typedef struct packed {
        logic                  valid;
        logic [RING_IDX_W-1:0] idx;
    } onehot_t;

    // dir=0 rotates towards the MSB with wrap to bit 0; dir=1 rotates towards the LSB.
    function automatic logic [RING_MAX_W-1:0] rotate(
        input logic [RING_MAX_W-1:0] value,
        input logic                  dir,
        input int                    width
    );
        logic [RING_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (i < width) begin
                if (!dir) r[(i + 1) % width] = value[i];
                else      r[i] = value[(i + 1) % width];
            end
        end
        return r;
    endfunction

    function automatic onehot_t onehot_idx(input logic [RING_MAX_W-1:0] value);
        onehot_t res;
        int      n;
        res = '0;
        n   = 0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (value[i]) begin
                n       = n + 1;
                res.idx = RING_IDX_W'(i);
            end
        end
        res.valid = (n == 1);
        return res;
    endfunction

endpackage

// File: rtl/ring_onehot_decoder.sv
// Combinational one-hot check and binary decode of a WIDTH-bit ring code.
module ring_onehot_decoder
    import ring_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring,
    output logic             onehot,
    output logic [IDXW-1:0]  index
);

    onehot_t dec;

    always_comb begin
        dec    = onehot_idx(RING_MAX_W'(ring));
        onehot = dec.valid;
        index  = IDXW'(dec.idx);
    end

endmodule

// File: rtl/ring_counter_monitor.sv
// In-system checker for a one-hot ring counter: decodes position, locks onto a
// correctly advancing sequence and counts sequence errors once locked.
module ring_counter_monitor
    import ring_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 4,
    parameter  bit DIR      = 1'b0,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             en,
    input  logic             clr_err,
    output logic [IDXW-1:0]  index,
    output logic             onehot_ok,
    output logic             locked,
    output logic             seq_err,
    output logic [7:0]       err_count
);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             en_q, en_d;
    ring_state_e      state_q, state_d;
    logic [7:0]       good_cnt_q, good_cnt_d;
    logic [IDXW-1:0]  index_q, index_d;
    logic             onehot_q, onehot_d;
    logic             seq_err_q, seq_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             in_onehot;
    logic [IDXW-1:0]  in_idx;
    logic [WIDTH-1:0] expected;
    logic             good;

    ring_onehot_decoder #(.WIDTH(WIDTH)) u_dec (
        .ring   (ring_in),
        .onehot (in_onehot),
        .index  (in_idx)
    );

    always_comb begin
        expected = en ? WIDTH'(rotate(RING_MAX_W'(prev_q), DIR, WIDTH)) : prev_q;
        good     = in_onehot && (ring_in == expected);
    end

    always_comb begin
        prev_d     = ring_in;
        en_d       = en;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        index_d    = in_onehot ? in_idx : index_q;
        onehot_d   = in_onehot;
        seq_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            HUNT: begin
                if (in_onehot) begin
                    state_d    = CHECK;
                    good_cnt_d = 8'd0;
                end
            end
            CHECK: begin
                if (good) begin
                    // A held ring (en=0) is good but must not advance the lock count.
                    if (en) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_d == 8'(LOCK_CNT)) state_d = LOCKED;
                    end
                end else begin
                    state_d    = in_onehot ? CHECK : HUNT;
                    good_cnt_d = 8'd0;
                end
            end
            LOCKED: begin
                if (!good) begin
                    seq_err_d  = 1'b1;
                    if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
                    state_d    = in_onehot ? CHECK : HUNT;
                    good_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = HUNT;
                good_cnt_d = 8'd0;
            end
        endcase

        if (clr_err) err_cnt_d = 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            en_q       <= 1'b0;
            state_q    <= HUNT;
            good_cnt_q <= 8'd0;
            index_q    <= '0;
            onehot_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            prev_q     <= prev_d;
            en_q       <= en_d;
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            index_q    <= index_d;
            onehot_q   <= onehot_d;
            seq_err_q  <= seq_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // en_q tracks the sampled enable alongside prev_q for debug probing.
    logic en_q_unused;
    assign en_q_unused = en_q;

    assign index     = index_q;
    assign onehot_ok = onehot_q;
    assign locked    = (state_q == LOCKED);
    assign seq_err   = seq_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Bench for ring_counter_monitor (WIDTH=4, LOCK_CNT=4, DIR=0): vector table plus
// a behavioural model feeding a scoreboard queue.
module tb_ring_counter_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ring_in;
    logic       en;
    logic       clr_err;
    logic [1:0] index;
    logic       onehot_ok;
    logic       locked;
    logic       seq_err;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;

    ring_counter_monitor #(.WIDTH(4), .LOCK_CNT(4), .DIR(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .ring_in   (ring_in),
        .en        (en),
        .clr_err   (clr_err),
        .index     (index),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic       oh;
        logic       lk;
        logic       se;
        logic [7:0] ec;
    } exp_t;

    typedef struct {
        logic [3:0] ring;
        logic       en;
        logic       clr;
        logic [1:0] idx;
        logic       oh;
        logic       lk;
        logic       se;
        logic [7:0] ec;
    } vec_t;

    exp_t sb[$];

    // Model state
    int         m_st;
    int         m_cnt;
    int         m_ec;
    logic [3:0] m_prev;
    logic [1:0] m_idx;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_ec = 0; m_prev = 4'b0000; m_idx = 2'd0;
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [3:0] r, input logic e, input logic c, output exp_t x);
        logic       oh;
        logic [1:0] id;
        logic [3:0] want;
        logic       good;
        logic       se;
        oh   = ($countones(r) == 1);
        id   = r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
        want = e ? rotl(m_prev) : m_prev;
        good = oh && (r == want);
        se   = 1'b0;
        case (m_st)
            0: if (oh) begin m_st = 1; m_cnt = 0; end
            1: begin
                if (good) begin
                    if (e) begin
                        m_cnt++;
                        if (m_cnt == 4) m_st = 2;
                    end
                end else begin
                    m_st = oh ? 1 : 0; m_cnt = 0;
                end
            end
            default: begin
                if (!good) begin
                    se = 1'b1;
                    if (m_ec < 255) m_ec++;
                    m_st = oh ? 1 : 0; m_cnt = 0;
                end
            end
        endcase
        if (c) m_ec = 0;
        if (oh) m_idx = id;
        m_prev = r;
        x.idx = m_idx; x.oh = oh; x.lk = (m_st == 2); x.se = se; x.ec = 8'(m_ec);
    endtask

    task automatic step(input logic [3:0] r, input logic e, input logic c);
        exp_t x;
        ring_in = r; en = e; clr_err = c;
        model(r, e, c, x);
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            chk("index", int'(index), int'(x.idx));
            chk("onehot_ok", int'(onehot_ok), int'(x.oh));
            chk("locked", int'(locked), int'(x.lk));
            chk("seq_err", int'(seq_err), int'(x.se));
            chk("err_count", int'(err_count), int'(x.ec));
        end
    endtask

    vec_t vt[$];
    logic [3:0] cur;

    initial begin
        // Clean lock, hold cycles, skipped step, illegal codes
        vt = '{
            '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0},
            '{4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0},
            '{4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0},
            '{4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0},
            '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0},
            '{4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'd1},
            '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1},
            '{4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1},
            '{4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1},
            '{4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd1},
            '{4'b0110, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd2},
            '{4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'd2}
        };

        reset = 1'b0; ring_in = 4'b0000; en = 1'b1; clr_err = 1'b0;
        model_reset();
        #1;
        chk("rst_index", int'(index), 0);
        chk("rst_onehot", int'(onehot_ok), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_seq_err", int'(seq_err), 0);
        chk("rst_err_count", int'(err_count), 0);
        #11 reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].ring, vt[i].en, vt[i].clr);
            chk($sformatf("vec%0d_index", i), int'(index), int'(vt[i].idx));
            chk($sformatf("vec%0d_onehot", i), int'(onehot_ok), int'(vt[i].oh));
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(vt[i].lk));
            chk($sformatf("vec%0d_seq_err", i), int'(seq_err), int'(vt[i].se));
            chk($sformatf("vec%0d_err_count", i), int'(err_count), int'(vt[i].ec));
        end

        // Relock from HUNT, then drive 300 locked-state errors with relock between each
        cur = 4'b0001;
        step(cur, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin cur = rotl(cur); step(cur, 1'b1, 1'b0); end
        chk("relock", int'(locked), 1);
        for (int n = 0; n < 300; n++) begin
            cur = rotl(rotl(cur));
            step(cur, 1'b1, 1'b0);
            for (int k = 0; k < 4; k++) begin cur = rotl(cur); step(cur, 1'b1, 1'b0); end
        end
        chk("sat_err_count", int'(err_count), 255);
        chk("sat_locked", int'(locked), 1);

        // Clear coincident with an error wins
        cur = rotl(rotl(cur));
        step(cur, 1'b1, 1'b1);
        chk("clr_seq_err", int'(seq_err), 1);
        chk("clr_err_count", int'(err_count), 0);
        for (int k = 0; k < 4; k++) begin cur = rotl(cur); step(cur, 1'b1, 1'b0); end
        cur = rotl(rotl(cur));
        step(cur, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin cur = rotl(cur); step(cur, 1'b1, 1'b0); end
        if (cur == 4'b0001) begin cur = rotl(cur); step(cur, 1'b1, 1'b0); end
        chk("pre_rst_locked", int'(locked), 1);
        chk("pre_rst_err_count", int'(err_count), 1);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_err_count", int'(err_count), 0);
        chk("async_index", int'(index), 0);
        chk("async_onehot", int'(onehot_ok), 0);
        model_reset();
        sb.delete();
        #1 reset = 1'b1;

        cur = 4'b0100;
        step(cur, 1'b1, 1'b0);
        chk("post_rst_not_locked", int'(locked), 0);
        for (int k = 0; k < 4; k++) begin cur = rotl(cur); step(cur, 1'b1, 1'b0); end
        chk("post_rst_relock", int'(locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
